// File: rtl/uart_pkg.sv
// Shared UART framing constants and transmitter state encoding.
// Frame format: one start bit, eight data bits sent LSB first, one stop bit.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } uart_state_t;

  localparam int   FRAME_BITS  = 10;
  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first asserted request at or above ptr, wrapping modulo NUM_REQ.
// Purely combinational, so a grant is available in the same cycle the request is seen.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // ptr + off never exceeds 2*NUM_REQ-2, so one subtraction is enough to wrap
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART line among NUM_REQ requesters: round-robin grant, then a 10-bit frame, one bit per clock.
// Start bit appears the cycle after the grant; requesters wait on level req until their ack pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDLE_BITS = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data_in,
  output logic [NUM_REQ-1:0]         ack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       signal
);
  import uart_pkg::*;

  localparam int         IW       = $clog2(NUM_REQ);
  localparam logic [3:0] GAP_LAST = (IDLE_BITS == 0) ? 4'd0 : 4'(IDLE_BITS - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  uart_state_t        state;
  logic [7:0]         shift;
  logic [2:0]         bit_cnt;
  logic [3:0]         gap_cnt;
  logic [IW-1:0]      ptr;

  logic [7:0]         req_byte [NUM_REQ];
  logic [NUM_REQ-1:0] win_grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_byte[g] = data_in[8*g +: 8];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // Ready marks the last cycle of the previous frame or gap, so a new frame starts with no dead cycle
  assign ready = (state == ST_IDLE)
              || (state == ST_STOP && IDLE_BITS == 0)
              || (state == ST_GAP  && gap_cnt == GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      ptr      <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      signal   <= IDLE_LEVEL;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      if (ready) begin
        if (win_any) begin
          shift    <= req_byte[win_idx];
          ack      <= win_grant;
          grant_id <= win_idx;
          ptr      <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          state    <= ST_START;
          signal   <= START_LEVEL;
          busy     <= 1'b1;
        end else begin
          state  <= ST_IDLE;
          signal <= IDLE_LEVEL;
          busy   <= 1'b0;
        end
      end else begin
        case (state)
          ST_START: begin
            state   <= ST_DATA;
            signal  <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= '0;
          end
          ST_DATA: begin
            if (bit_cnt == BIT_LAST) begin
              state  <= ST_STOP;
              signal <= STOP_LEVEL;
              done   <= 1'b1;
            end else begin
              signal  <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_STOP: begin
            // Only reached with a non-zero gap; a zero gap makes STOP a ready state
            state   <= ST_GAP;
            gap_cnt <= '0;
            signal  <= IDLE_LEVEL;
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt + 4'd1;
            signal  <= IDLE_LEVEL;
          end
          default: begin
            state  <= ST_IDLE;
            signal <= IDLE_LEVEL;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
